// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one icache request per instruction,
// resolves the next PC (JAL, predicted conditional branches, sequential), and buffers
// fetched instructions with their address and taken bit in a circular queue for decode.
// A ROB flush discards queued and in-flight work and restarts at the redirect PC.
module fetch_unit #(
  parameter int unsigned QUEUE_WIDTH = 3,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clockIn,
  input  logic        resetIn,
  output logic        icacheAddrValid,
  output logic [31:0] icacheAddr,
  input  logic        icacheInstrValid,
  input  logic [31:0] icacheInstr,
  output logic        predictorInstrValid,
  output logic [31:0] predictorAddr,
  input  logic        predictorJump,
  input  logic        robFlush,
  input  logic [31:0] robRedirectPc,
  input  logic        decoderReady,
  output logic        instrOutValid,
  output logic [31:0] instrOut,
  output logic [31:0] instrOutAddr,
  output logic        instrOutJump
);

  localparam int unsigned DEPTH = 1 << QUEUE_WIDTH;

  localparam logic [QUEUE_WIDTH:0]   CNT_FULL = {1'b1, {QUEUE_WIDTH{1'b0}}};
  localparam logic [QUEUE_WIDTH:0]   CNT_ONE  = {{QUEUE_WIDTH{1'b0}}, 1'b1};
  localparam logic [QUEUE_WIDTH-1:0] PTR_ONE  = {{(QUEUE_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_REQUEST,
    S_WAIT,
    S_PREDICT,
    S_STALL,
    S_DISCARD
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] instr_q;
  logic        addr_valid_q;
  logic        addr_valid_next;

  logic        push;
  logic        push_jump;
  logic        pop;

  logic [QUEUE_WIDTH-1:0] head;
  logic [QUEUE_WIDTH-1:0] tail;
  logic [QUEUE_WIDTH:0]   count;
  logic                   full;
  logic                   empty;

  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_addr  [DEPTH];
  logic        q_jump  [DEPTH];

  logic [6:0]  opcode;
  logic [31:0] imm_j;
  logic [31:0] imm_b;

  assign opcode = instr_q[6:0];
  assign imm_j  = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign imm_b  = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  assign icacheAddrValid = addr_valid_q;
  assign icacheAddr      = pc;
  assign predictorAddr   = pc;

  assign instrOutValid = !empty;
  assign instrOut      = q_instr[head];
  assign instrOutAddr  = q_addr[head];
  assign instrOutJump  = q_jump[head];

  // Pop only a non-empty queue; a flush overrides it in the pointer update.
  assign pop = decoderReady && !empty;

  // Next-state, next-PC and push decisions; flush is applied last so it wins.
  always_comb begin
    state_next          = state;
    pc_next             = pc;
    addr_valid_next     = 1'b0;
    push                = 1'b0;
    push_jump           = 1'b0;
    predictorInstrValid = 1'b0;

    case (state)
      S_REQUEST: begin
        if (!full) begin
          addr_valid_next = 1'b1;
          state_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (icacheInstrValid) begin
          predictorInstrValid = 1'b1;
          state_next          = S_PREDICT;
        end
      end
      S_PREDICT: begin
        push       = 1'b1;
        state_next = S_REQUEST;
        case (opcode)
          OP_JAL: begin
            push_jump = 1'b1;
            pc_next   = pc + imm_j;
          end
          OP_BRANCH: begin
            push_jump = predictorJump;
            pc_next   = predictorJump ? (pc + imm_b) : (pc + 32'd4);
          end
          OP_JALR: begin
            state_next = S_STALL;
          end
          default: begin
            pc_next = pc + 32'd4;
          end
        endcase
      end
      S_STALL: begin
      end
      S_DISCARD: begin
        if (icacheInstrValid) begin
          state_next = S_REQUEST;
        end
      end
      default: begin
        state_next = S_REQUEST;
      end
    endcase

    if (robFlush) begin
      // An outstanding request with no response yet must have its response dropped.
      pc_next             = robRedirectPc;
      push                = 1'b0;
      push_jump           = 1'b0;
      addr_valid_next     = 1'b0;
      predictorInstrValid = 1'b0;
      state_next          = (state == S_WAIT && !icacheInstrValid) ? S_DISCARD : S_REQUEST;
    end
  end

  // Control registers: state, PC, request pulse and the latched instruction word.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      state        <= S_REQUEST;
      pc           <= RESET_PC;
      addr_valid_q <= 1'b0;
      instr_q      <= '0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      addr_valid_q <= addr_valid_next;
      if (state == S_WAIT && icacheInstrValid && !robFlush) begin
        instr_q <= icacheInstr;
      end
    end
  end

  // Queue pointers and occupancy; flush empties the queue regardless of push/pop.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (robFlush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; entries are only meaningful below the occupancy count.
  always_ff @(posedge clockIn) begin
    if (push) begin
      q_instr[tail] <= instr_q;
      q_addr[tail]  <= pc;
      q_jump[tail]  <= push_jump;
    end
  end

endmodule
